// File: rtl/regfile_writeback_if.sv
// Write-side bus bundle for regfile_writeback_unit: ALU and long-latency result inputs,
// scoreboard queries and the register-file write port.
interface regfile_writeback_if #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             ll_valid;
    logic             ll_ready;
    logic [4:0]       ll_rd;
    logic [XLEN-1:0]  ll_data;
    logic             sb_set;
    logic [4:0]       sb_rd;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             alu_stall;
    logic [CNT_W-1:0] fifo_count;
    logic             rd_we;
    logic [4:0]       rd_addr;
    logic [XLEN-1:0]  rd_data;

    modport master (
        output alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data,
               sb_set, sb_rd, rs1_addr, rs2_addr,
        input  ll_ready, rs1_busy, rs2_busy, alu_stall, fifo_count,
               rd_we, rd_addr, rd_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data,
               sb_set, sb_rd, rs1_addr, rs2_addr,
        output ll_ready, rs1_busy, rs2_busy, alu_stall, fifo_count,
               rd_we, rd_addr, rd_data
    );
endinterface

// File: rtl/regfile_writeback_unit.sv
// Arbitrates ALU and buffered long-latency results onto the single register-file write
// port, with starvation control and a per-register pending scoreboard for issue.
module regfile_writeback_unit #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_writeback_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic             stall_q, stall_d;
    logic [31:0]      busy_q, busy_d;
    logic             rd_we_q, rd_we_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]  rd_data_q, rd_data_d;

    logic            full, empty, push, pop, alu_win;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = bus.ll_valid && !full;
    assign alu_win   = bus.alu_valid && !stall_q;
    assign pop       = !alu_win && !empty;
    assign head_rd   = fifo_rd_q[head_q];
    assign head_data = fifo_data_q[head_q];

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        starve_d  = starve_q;
        stall_d   = 1'b0;
        busy_d    = busy_q;
        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;

        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The stall pulse forces exactly one FIFO drain after STARVE_MAX lost arbitrations.
        if (pop || empty) begin
            starve_d = '0;
        end else if (alu_win) begin
            if (starve_q == SC_W'(STARVE_MAX - 1)) begin
                stall_d  = 1'b1;
                starve_d = '0;
            end else begin
                starve_d = starve_q + SC_W'(1);
            end
        end

        if (alu_win) begin
            rd_we_d   = (bus.alu_rd != 5'd0);
            rd_addr_d = bus.alu_rd;
            rd_data_d = bus.alu_data;
        end else if (pop) begin
            rd_we_d   = (head_rd != 5'd0);
            rd_addr_d = head_rd;
            rd_data_d = head_data;
        end

        // Clear first so a same-cycle dispatch to the same register keeps it pending.
        if (pop) busy_d[head_rd] = 1'b0;
        if (bus.sb_set && (bus.sb_rd != 5'd0)) busy_d[bus.sb_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            busy_q    <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            busy_q    <= busy_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[tail_q]   <= bus.ll_rd;
            fifo_data_q[tail_q] <= bus.ll_data;
        end
    end

    assign bus.ll_ready   = !full;
    assign bus.rs1_busy   = busy_q[bus.rs1_addr];
    assign bus.rs2_busy   = busy_q[bus.rs2_addr];
    assign bus.alu_stall  = stall_q;
    assign bus.fifo_count = count_q;
    assign bus.rd_we      = rd_we_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench for regfile_writeback_unit: reset, ALU writes, scoreboard, FIFO full,
// starvation drain order, set/clear collision and asynchronous reset mid-operation.
module tb_regfile_writeback_unit;
    logic clk;
    logic rst_n;
    int   compared;
    int   failed;

    regfile_writeback_if #(.XLEN(32), .FIFO_DEPTH(4)) bus ();

    regfile_writeback_unit #(.XLEN(32), .FIFO_DEPTH(4), .STARVE_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'd0;
        bus.ll_valid  = 1'b0;
        bus.ll_rd     = 5'd0;
        bus.ll_data   = 32'd0;
        bus.sb_set    = 1'b0;
        bus.sb_rd     = 5'd0;
    endtask

    logic [4:0]  fr [4];
    logic [31:0] fd [4];

    initial begin
        compared = 0;
        failed   = 0;
        fr[0] = 5'd2; fr[1] = 5'd3; fr[2] = 5'd4; fr[3] = 5'd6;
        fd[0] = 32'h2222_0002; fd[1] = 32'h3333_0003;
        fd[2] = 32'h4444_0004; fd[3] = 32'h6666_0006;

        idle();
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset then idle
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_rd_we", bus.rd_we, 0);
            chk("reset_ll_ready", bus.ll_ready, 1);
            chk("reset_fifo_count", bus.fifo_count, 0);
            chk("reset_rs1_busy", bus.rs1_busy, 0);
            chk("reset_rs2_busy", bus.rs2_busy, 0);
            chk("reset_alu_stall", bus.alu_stall, 0);
        end

        // ALU write, hold on idle, x0 suppressed
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd1;
        bus.alu_data  = 32'hDEAD_BEEF;
        step();
        chk("alu_rd_we", bus.rd_we, 1);
        chk("alu_rd_addr", bus.rd_addr, 1);
        chk("alu_rd_data", bus.rd_data, 32'hDEAD_BEEF);
        bus.alu_valid = 1'b0;
        step();
        chk("hold_rd_we", bus.rd_we, 0);
        chk("hold_rd_addr", bus.rd_addr, 1);
        chk("hold_rd_data", bus.rd_data, 32'hDEAD_BEEF);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'h1234_5678;
        step();
        chk("alu_x0_rd_we", bus.rd_we, 0);
        idle();

        // Scoreboard round trip
        bus.sb_set = 1'b1;
        bus.sb_rd  = 5'd5;
        step();
        bus.sb_set = 1'b0;
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd0;
        #1;
        chk("sb_rs1_busy_set", bus.rs1_busy, 1);
        chk("sb_x0_never_busy", bus.rs2_busy, 0);
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd5;
        bus.ll_data  = 32'hCAFE_BABE;
        step();
        bus.ll_valid = 1'b0;
        chk("sb_push_count", bus.fifo_count, 1);
        chk("sb_push_no_fallthrough", bus.rd_we, 0);
        chk("sb_still_busy", bus.rs1_busy, 1);
        step();
        chk("sb_pop_rd_we", bus.rd_we, 1);
        chk("sb_pop_rd_addr", bus.rd_addr, 5);
        chk("sb_pop_rd_data", bus.rd_data, 32'hCAFE_BABE);
        chk("sb_pop_clears_busy", bus.rs1_busy, 0);
        chk("sb_pop_count", bus.fifo_count, 0);

        // Fill FIFO while ALU wins every cycle
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd10;
        for (int i = 0; i < 4; i++) begin
            bus.alu_data = 32'hA000_0000 + i;
            bus.ll_valid = 1'b1;
            bus.ll_rd    = fr[i];
            bus.ll_data  = fd[i];
            step();
            chk("fill_rd_addr", bus.rd_addr, 10);
            chk("fill_rd_data", bus.rd_data, 32'hA000_0000 + i);
            chk("fill_count", bus.fifo_count, i + 1);
            chk("fill_alu_stall", bus.alu_stall, (i == 3));
        end
        chk("full_ll_ready", bus.ll_ready, 0);

        // Fifth offer refused; stall cycle drains head despite alu_valid
        bus.ll_rd    = 5'd9;
        bus.ll_data  = 32'h9999_9999;
        bus.alu_data = 32'hA000_0004;
        step();
        bus.ll_valid = 1'b0;
        chk("drain0_rd_we", bus.rd_we, 1);
        chk("drain0_rd_addr", bus.rd_addr, 2);
        chk("drain0_rd_data", bus.rd_data, fd[0]);
        chk("drain0_count_no_push", bus.fifo_count, 3);
        chk("drain0_stall_done", bus.alu_stall, 0);

        // Starvation drain order: 3 ALU writes then one FIFO pop
        for (int i = 0; i < 12; i++) begin
            bus.alu_data = 32'hB000_0000 + i;
            step();
            if (i % 4 == 3) begin
                chk("starve_pop_rd_addr", bus.rd_addr, fr[i / 4 + 1]);
                chk("starve_pop_rd_data", bus.rd_data, fd[i / 4 + 1]);
            end else begin
                chk("starve_alu_rd_addr", bus.rd_addr, 10);
                chk("starve_alu_rd_data", bus.rd_data, 32'hB000_0000 + i);
            end
            chk("starve_alu_stall", bus.alu_stall, (i % 4 == 2));
            chk("starve_count", bus.fifo_count, 3 - (i + 1) / 4);
        end
        idle();
        step();
        chk("starve_done_rd_we", bus.rd_we, 0);

        // Set/clear collision on register 7
        bus.sb_set = 1'b1;
        bus.sb_rd  = 5'd7;
        step();
        bus.sb_set   = 1'b0;
        bus.rs2_addr = 5'd7;
        #1;
        chk("coll_busy_before", bus.rs2_busy, 1);
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd7;
        bus.ll_data  = 32'h7777_0007;
        step();
        bus.ll_valid = 1'b0;
        bus.sb_set   = 1'b1;
        bus.sb_rd    = 5'd7;
        step();
        bus.sb_set = 1'b0;
        chk("coll_rd_addr", bus.rd_addr, 7);
        chk("coll_rd_data", bus.rd_data, 32'h7777_0007);
        chk("coll_busy_kept", bus.rs2_busy, 1);
        chk("coll_count", bus.fifo_count, 0);

        // Asynchronous reset with three buffered entries
        bus.rs1_addr  = 5'd12;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd11;
        bus.alu_data  = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            bus.ll_valid = 1'b1;
            bus.ll_rd    = 5'd12 + 5'(i);
            bus.ll_data  = 32'hC000_0000 + i;
            bus.sb_set   = (i == 0);
            bus.sb_rd    = 5'd12;
            step();
        end
        bus.ll_valid = 1'b0;
        bus.sb_set   = 1'b0;
        #1;
        chk("pre_rst_count", bus.fifo_count, 3);
        chk("pre_rst_busy12", bus.rs1_busy, 1);
        chk("pre_rst_rd_we", bus.rd_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd_we", bus.rd_we, 0);
        chk("async_rst_rd_addr", bus.rd_addr, 0);
        chk("async_rst_rd_data", bus.rd_data, 0);
        chk("async_rst_count", bus.fifo_count, 0);
        chk("async_rst_busy12", bus.rs1_busy, 0);
        chk("async_rst_busy7", bus.rs2_busy, 0);
        idle();
        step();
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_rd_we", bus.rd_we, 0);
        chk("post_rst_count", bus.fifo_count, 0);
        chk("post_rst_ll_ready", bus.ll_ready, 1);
        chk("post_rst_busy12", bus.rs1_busy, 0);
        chk("post_rst_busy7", bus.rs2_busy, 0);
        chk("post_rst_stall", bus.alu_stall, 0);
        step();
        chk("post_rst_no_stale_pop", bus.rd_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
